// File: rtl/rx_deser_par_chk.sv
// UART RX back end: shifts in the sampled frame bits LSB first, checks parity and
// stop bit, and reports the word with a one-cycle valid or error strobe.
module rx_deser_par_chk #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             parity_enable,
    input  logic             parity_type,
    input  logic             frame_start,
    input  logic             bit_valid,
    input  logic             sampled_bit,
    output logic [WIDTH-1:0] P_DATA,
    output logic             Data_Valid,
    output logic             par_err,
    output logic             stp_err,
    output logic             Busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_pdata;
    logic             r_pen;
    logic             r_ptype;
    logic             r_perr_hold;
    logic             r_dv;
    logic             r_par_err;
    logic             r_stp_err;
    logic             w_exp_par;

    assign w_exp_par = (^r_shift) ^ r_ptype;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_pdata     <= '0;
            r_pen       <= 1'b0;
            r_ptype     <= 1'b0;
            r_perr_hold <= 1'b0;
            r_dv        <= 1'b0;
            r_par_err   <= 1'b0;
            r_stp_err   <= 1'b0;
        end else begin
            r_dv      <= 1'b0;
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;
            // frame_start has priority in every state; a frame in flight is dropped silently
            if (frame_start) begin
                r_state     <= DATA;
                r_cnt       <= '0;
                r_shift     <= '0;
                r_pen       <= parity_enable;
                r_ptype     <= parity_type;
                r_perr_hold <= 1'b0;
            end else if (bit_valid) begin
                case (r_state)
                    DATA: begin
                        r_shift <= {sampled_bit, r_shift[WIDTH-1:1]};
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == LAST_BIT)
                            r_state <= r_pen ? PARITY : STOP;
                    end
                    PARITY: begin
                        r_perr_hold <= (sampled_bit != w_exp_par);
                        r_state     <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (sampled_bit && !r_perr_hold) begin
                            r_dv    <= 1'b1;
                            r_pdata <= r_shift;
                        end else begin
                            r_par_err <= r_perr_hold;
                            r_stp_err <= ~sampled_bit;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign P_DATA     = r_pdata;
    assign Data_Valid = r_dv;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;
    assign Busy       = (r_state != IDLE);

endmodule

// File: tb/tb_rx_deser_par_chk.sv
// Directed bench for rx_deser_par_chk: good frames, parity/stop errors, abort,
// config latching and asynchronous reset mid-frame.
module tb_rx_deser_par_chk;
    logic       CLK = 1'b0;
    logic       RST;
    logic       parity_enable;
    logic       parity_type;
    logic       frame_start;
    logic       bit_valid;
    logic       sampled_bit;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       par_err;
    logic       stp_err;
    logic       Busy;

    int n_chk = 0;
    int n_err = 0;

    rx_deser_par_chk #(.WIDTH(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .frame_start  (frame_start),
        .bit_valid    (bit_valid),
        .sampled_bit  (sampled_bit),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .Busy         (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic dv, input logic pe,
                           input logic se, input logic bsy, input logic [7:0] pd);
        chk({tag, ".dv"},   32'(Data_Valid), 32'(dv));
        chk({tag, ".pe"},   32'(par_err),    32'(pe));
        chk({tag, ".se"},   32'(stp_err),    32'(se));
        chk({tag, ".busy"}, 32'(Busy),       32'(bsy));
        chk({tag, ".pd"},   32'(P_DATA),     32'(pd));
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    // One frame_start pulse; optionally a coincident bit_valid that must be dropped
    task automatic start_frame(input logic pen, input logic ptype, input logic with_bit);
        cycle();
        parity_enable = pen;
        parity_type   = ptype;
        frame_start   = 1'b1;
        bit_valid     = with_bit;
        sampled_bit   = 1'b1;
        cycle();
        frame_start = 1'b0;
        bit_valid   = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        cycle();
        bit_valid   = 1'b1;
        sampled_bit = b;
        cycle();
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] d, input int first, input int last);
        for (int i = first; i <= last; i++) send_bit(d[i]);
    endtask

    initial begin
        RST = 1'b0; parity_enable = 1'b0; parity_type = 1'b0;
        frame_start = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b0;
        cycle(); cycle();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        RST = 1'b1;
        cycle();

        // 1: even parity 0xA5, parity 0, stop 1
        start_frame(1'b1, 1'b0, 1'b0);
        chk("t1.busy_after_start", 32'(Busy), 32'd1);
        send_bits(8'hA5, 0, 7);
        send_bit(1'b0);
        send_bit(1'b1);
        chk_out("t1.done", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
        cycle();
        chk("t1.dv_one_cycle", 32'(Data_Valid), 32'd0);

        // 2: odd parity 0xA5 with parity bit 0 -> parity error
        start_frame(1'b1, 1'b1, 1'b0);
        send_bits(8'hA5, 0, 7);
        send_bit(1'b0);
        send_bit(1'b1);
        chk_out("t2.done", 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
        cycle();
        chk("t2.pe_one_cycle", 32'(par_err), 32'd0);

        // 3a: no parity 0x3C, stop 0
        start_frame(1'b0, 1'b0, 1'b0);
        send_bits(8'h3C, 0, 7);
        chk("t3a.busy_at_stop", 32'(Busy), 32'd1);
        send_bit(1'b0);
        chk_out("t3a.done", 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);

        // 3b: odd 0x01, parity 1 (wrong), stop 0 -> both errors
        start_frame(1'b1, 1'b1, 1'b0);
        send_bits(8'h01, 0, 7);
        send_bit(1'b1);
        send_bit(1'b0);
        chk_out("t3b.done", 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);

        // 4: abort after 4 bits, restart with a coincident bit that must be dropped
        start_frame(1'b1, 1'b0, 1'b0);
        send_bits(8'hFF, 0, 3);
        start_frame(1'b1, 1'b0, 1'b1);
        chk_out("t4.abort", 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
        send_bits(8'h5A, 0, 7);
        send_bit(1'b0);
        send_bit(1'b1);
        chk_out("t4.done", 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);

        // 5: parity_type flipped mid-frame is ignored
        start_frame(1'b1, 1'b0, 1'b0);
        send_bits(8'h0F, 0, 3);
        parity_type = 1'b1;
        send_bits(8'h0F, 4, 7);
        send_bit(1'b0);
        send_bit(1'b1);
        chk_out("t5.done", 1'b1, 1'b0, 1'b0, 1'b0, 8'h0F);

        // 6: async reset after bit 5, then stray bit_valids
        start_frame(1'b1, 1'b0, 1'b0);
        send_bits(8'h33, 0, 5);
        RST = 1'b0;
        #1;
        chk_out("t6.reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle();
        RST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_bit(1'b1);
            chk_out("t6.stray", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
